// File: rtl/pe_scan.sv
// pe_scan: serialises a multi-hot request vector into set-bit indices,
// one per accepted output beat, in MSB-first or LSB-first priority order.
module pe_scan #(
    parameter int unsigned W         = 8,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned OW       = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_vec,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_idx,
    output logic          out_last,
    output logic          zero,
    output logic          busy
);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  rem_q, rem_d;
    logic          zero_q, zero_d;
    logic [OW-1:0] idx;
    logic          one_left;

    // Priority decode: the last match in loop order wins
    always_comb begin
        idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < int'(W); i++) begin
                if (rem_q[i]) idx = OW'(i);
            end
        end else begin
            for (int i = int'(W) - 1; i >= 0; i--) begin
                if (rem_q[i]) idx = OW'(i);
            end
        end
    end

    // Exactly one bit remaining marks the final beat
    always_comb begin
        one_left = (rem_q != '0) && ((rem_q & (rem_q - W'(1))) == '0);
    end

    // Outputs decoded from registered state; idle beats read as zero
    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q == StScan);
        out_valid = (state_q == StScan);
        out_idx   = out_valid ? idx : '0;
        out_last  = out_valid && one_left;
        zero      = zero_q;
    end

    // Next-state: accept in IDLE, retire one index per handshake in SCAN
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        zero_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    rem_d = in_vec;
                    if (in_vec == '0) begin
                        zero_d = 1'b1;
                    end else begin
                        state_d = StScan;
                    end
                end
            end
            StScan: begin
                if (out_ready) begin
                    rem_d = rem_q & ~(W'(1) << idx);
                    if (one_left) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: doc/pe_scan.md
Name: pe_scan

Overview:
- Parametrised, sequential successor to the 8-bit combinational priority encoder.
- Accepts a W-bit request vector via a valid/ready handshake.
- Emits the index of every set bit, one per accepted output beat, in priority order (MSB-first or LSB-first), then returns to idle.
- Used wherever a multi-hot vector must be serialised into indices, such as interrupt pending sets or free-slot lists.

Parameters:
- W, 8, request vector width; must be at least 2.
- OW, $clog2(W), index width; derived, not overridden.
- MSB_FIRST, 1, 1 = highest set index emitted first (matches the existing pe_8b priority); 0 = lowest first.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request vector present.
- in_ready  output  1  block can accept a vector.
- in_vec  input  W  request vector.
- out_valid  output  1  out_idx is valid.
- out_ready  input  1  consumer accepts out_idx.
- out_idx  output  OW  index of the current highest-priority remaining bit.
- out_last  output  1  current beat is the final index of this vector.
- zero  output  1  one-cycle pulse: an accepted vector was all zeros.
- busy  output  1  scan in progress (state SCAN).

Behaviour:
- Reset values, applied on the clk edge where rst=1:
  - State = IDLE, internal remaining register = 0.
  - out_valid=0, out_idx=0, out_last=0, zero=0, busy=0, in_ready=1.
- Two states: IDLE and SCAN. in_ready = (state==IDLE); busy = (state==SCAN).
- IDLE:
  - On in_valid && in_ready, latch in_vec into rem.
  - If in_vec==0: stay IDLE and assert zero for exactly the next cycle. No out_valid beat is produced.
  - Otherwise: go to SCAN. out_valid rises on the next cycle, so latency from acceptance to first index is 1 cycle.
- SCAN:
  - out_valid=1.
  - out_idx = position of the highest set bit of rem when MSB_FIRST=1, lowest set bit when MSB_FIRST=0. It is a combinational decode of the registered rem and is stable while out_valid && !out_ready.
  - out_last=1 when rem has exactly one set bit.
  - On out_valid && out_ready: clear bit out_idx in rem. If out_last, go to IDLE, so in_ready is 1 on the following cycle.
  - Throughput is one index per cycle while out_ready is held high. A vector with k set bits occupies exactly k beats.
- Backpressure: while out_ready=0, rem, out_idx and out_last hold. There is no timeout.
- No overlap: in_ready is 0 throughout SCAN, so a new vector is accepted no earlier than the cycle after the last beat. in_vec is ignored when in_ready=0.
- Idle-cycle outputs: out_idx=0 and out_last=0 whenever out_valid=0.
- Reset mid-scan: rst overrides everything. On the next cycle out_valid=0, in_ready=1, rem=0, and any pending indices are discarded.
- Simultaneous in_valid and rst: rst wins; the vector is not accepted.
- Boundary: all-ones vector yields W beats, indices W-1..0 (MSB_FIRST=1) or 0..W-1 (MSB_FIRST=0); out_last on the final one.
- Width rule: OW = $clog2(W). For non-power-of-2 W, out_idx never exceeds W-1.

Test Plan:
1. W=8, MSB_FIRST=1: after reset check in_ready=1, out_valid=0, zero=0. Present in_vec=8'b00000000 -> zero=1 for one cycle, out_valid stays 0, in_ready stays 1.
2. W=8, MSB_FIRST=1: in_vec=8'b00000100, out_ready=1 -> one cycle later a single beat out_idx=2 with out_last=1, then in_ready=1.
3. W=8, MSB_FIRST=1: in_vec=8'b01000101, out_ready=1 -> consecutive beats out_idx 6, 2, 0; out_last only on idx 0; in_ready=0 for those 3 cycles.
4. Backpressure with the same vector: hold out_ready=0 for 3 cycles -> out_idx=6 stable and out_valid=1 throughout. Release -> 6, 2, 0 follow with no beat lost or duplicated.
5. MSB_FIRST=0, W=8: in_vec=8'b01000101 -> beats 0, 2, 6. W=16: in_vec=16'h8001 -> beats 15, 0 (MSB_FIRST=1); in_vec=16'hFFFF -> 16 beats, 15..0.
6. Reset mid-scan: accept 8'b11110000, take one beat (idx 7), assert rst for 1 cycle -> next cycle out_valid=0, busy=0, in_ready=1. A new vector 8'b00000010 then yields a single beat, idx 1.
